// File: rtl/rgb_window_generator.sv
// Streaming 3x3 RGB window builder: two line buffers feed a 3x3 shift window,
// and interior positions emit through a valid/ready output register.
module rgb_window_generator #(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 48
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic       in_sof,
   input  logic [7:0] in_red,
   input  logic [7:0] in_green,
   input  logic [7:0] in_blue,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] pixel_0_red, output logic [7:0] pixel_0_green, output logic [7:0] pixel_0_blue,
   output logic [7:0] pixel_1_red, output logic [7:0] pixel_1_green, output logic [7:0] pixel_1_blue,
   output logic [7:0] pixel_2_red, output logic [7:0] pixel_2_green, output logic [7:0] pixel_2_blue,
   output logic [7:0] pixel_3_red, output logic [7:0] pixel_3_green, output logic [7:0] pixel_3_blue,
   output logic [7:0] pixel_4_red, output logic [7:0] pixel_4_green, output logic [7:0] pixel_4_blue,
   output logic [7:0] pixel_5_red, output logic [7:0] pixel_5_green, output logic [7:0] pixel_5_blue,
   output logic [7:0] pixel_6_red, output logic [7:0] pixel_6_green, output logic [7:0] pixel_6_blue,
   output logic [7:0] pixel_7_red, output logic [7:0] pixel_7_green, output logic [7:0] pixel_7_blue,
   output logic [7:0] pixel_8_red, output logic [7:0] pixel_8_green, output logic [7:0] pixel_8_blue
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   logic [CW-1:0]     col_q, col_d, col_cur;
   logic [RW-1:0]     row_q, row_d, row_cur;
   logic [23:0]       line0_q [IMG_WIDTH];
   logic [23:0]       line1_q [IMG_WIDTH];
   logic [8:0][23:0]  win_q, win_d;
   logic [8:0][23:0]  out_q, out_d;
   logic              out_valid_q, out_valid_d;
   logic              accept, emit;
   logic [23:0]       pix_in;

   assign pix_in   = {in_red, in_green, in_blue};
   assign in_ready = !out_valid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // in_sof relocates the current pixel to (0,0) before any indexing or emit decision
   assign col_cur = in_sof ? '0 : col_q;
   assign row_cur = in_sof ? '0 : row_q;
   assign emit    = accept && (row_cur >= RW'(2)) && (col_cur >= CW'(2));

   always_comb begin
      col_d       = col_q;
      row_d       = row_q;
      win_d       = win_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      if (accept) begin
         if (col_cur == CW'(IMG_WIDTH - 1)) begin
            col_d = '0;
            row_d = (row_cur == RW'(IMG_HEIGHT - 1)) ? '0 : row_cur + 1'b1;
         end else begin
            col_d = col_cur + 1'b1;
            row_d = row_cur;
         end
         for (int unsigned r = 0; r < 3; r++) begin
            win_d[3*r]   = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
         end
         win_d[2] = line0_q[col_cur];
         win_d[5] = line1_q[col_cur];
         win_d[8] = pix_in;
      end
      if (emit) begin
         out_d       = win_d;
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_q       <= '0;
         row_q       <= '0;
         win_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         win_q       <= win_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Line buffers carry no reset; stale contents are never reachable by an emitted window
   always_ff @(posedge clk) begin
      if (accept) begin
         line0_q[col_cur] <= line1_q[col_cur];
         line1_q[col_cur] <= pix_in;
      end
   end

   assign out_valid = out_valid_q;
   assign {pixel_0_red, pixel_0_green, pixel_0_blue} = out_q[0];
   assign {pixel_1_red, pixel_1_green, pixel_1_blue} = out_q[1];
   assign {pixel_2_red, pixel_2_green, pixel_2_blue} = out_q[2];
   assign {pixel_3_red, pixel_3_green, pixel_3_blue} = out_q[3];
   assign {pixel_4_red, pixel_4_green, pixel_4_blue} = out_q[4];
   assign {pixel_5_red, pixel_5_green, pixel_5_blue} = out_q[5];
   assign {pixel_6_red, pixel_6_green, pixel_6_blue} = out_q[6];
   assign {pixel_7_red, pixel_7_green, pixel_7_blue} = out_q[7];
   assign {pixel_8_red, pixel_8_green, pixel_8_blue} = out_q[8];

endmodule

// File: tb/tb_rgb_window_generator.sv
// Scoreboard bench: a frame-image reference model predicts windows; a negedge monitor checks them.
module tb_rgb_window_generator;

   localparam int W  = 4;
   localparam int H  = 4;
   localparam int BW = 64;
   localparam int BH = 48;

   typedef logic [8:0][23:0] win_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, in_valid, in_ready, in_sof, out_valid, out_ready;
   logic [7:0] in_red, in_green, in_blue;
   win_t       act;
   logic       b_in_valid, b_in_ready, b_in_sof, b_out_valid, b_out_ready;
   win_t       b_act;

   rgb_window_generator #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
      .in_red(in_red), .in_green(in_green), .in_blue(in_blue),
      .out_valid(out_valid), .out_ready(out_ready),
      .pixel_0_red(act[0][23:16]), .pixel_0_green(act[0][15:8]), .pixel_0_blue(act[0][7:0]),
      .pixel_1_red(act[1][23:16]), .pixel_1_green(act[1][15:8]), .pixel_1_blue(act[1][7:0]),
      .pixel_2_red(act[2][23:16]), .pixel_2_green(act[2][15:8]), .pixel_2_blue(act[2][7:0]),
      .pixel_3_red(act[3][23:16]), .pixel_3_green(act[3][15:8]), .pixel_3_blue(act[3][7:0]),
      .pixel_4_red(act[4][23:16]), .pixel_4_green(act[4][15:8]), .pixel_4_blue(act[4][7:0]),
      .pixel_5_red(act[5][23:16]), .pixel_5_green(act[5][15:8]), .pixel_5_blue(act[5][7:0]),
      .pixel_6_red(act[6][23:16]), .pixel_6_green(act[6][15:8]), .pixel_6_blue(act[6][7:0]),
      .pixel_7_red(act[7][23:16]), .pixel_7_green(act[7][15:8]), .pixel_7_blue(act[7][7:0]),
      .pixel_8_red(act[8][23:16]), .pixel_8_green(act[8][15:8]), .pixel_8_blue(act[8][7:0])
   );

   rgb_window_generator #(.IMG_WIDTH(BW), .IMG_HEIGHT(BH)) u_big (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sof(b_in_sof),
      .in_red(8'd90), .in_green(8'd90), .in_blue(8'd90),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
      .pixel_0_red(b_act[0][23:16]), .pixel_0_green(b_act[0][15:8]), .pixel_0_blue(b_act[0][7:0]),
      .pixel_1_red(b_act[1][23:16]), .pixel_1_green(b_act[1][15:8]), .pixel_1_blue(b_act[1][7:0]),
      .pixel_2_red(b_act[2][23:16]), .pixel_2_green(b_act[2][15:8]), .pixel_2_blue(b_act[2][7:0]),
      .pixel_3_red(b_act[3][23:16]), .pixel_3_green(b_act[3][15:8]), .pixel_3_blue(b_act[3][7:0]),
      .pixel_4_red(b_act[4][23:16]), .pixel_4_green(b_act[4][15:8]), .pixel_4_blue(b_act[4][7:0]),
      .pixel_5_red(b_act[5][23:16]), .pixel_5_green(b_act[5][15:8]), .pixel_5_blue(b_act[5][7:0]),
      .pixel_6_red(b_act[6][23:16]), .pixel_6_green(b_act[6][15:8]), .pixel_6_blue(b_act[6][7:0]),
      .pixel_7_red(b_act[7][23:16]), .pixel_7_green(b_act[7][15:8]), .pixel_7_blue(b_act[7][7:0]),
      .pixel_8_red(b_act[8][23:16]), .pixel_8_green(b_act[8][15:8]), .pixel_8_blue(b_act[8][7:0])
   );

   int   checks = 0, errors = 0, windows = 0, b_windows = 0;
   int   next_pos = 0;
   int   ready_mode = 0;   // 0: always ready, 1: random, 2: stalled
   win_t exp_q[$];
   logic [23:0] img [W*H];

   task automatic chk(input string name, input logic [215:0] got, input logic [215:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic chk_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Reference: remember the frame as an image, emit any interior 3x3 neighbourhood.
   task automatic model_accept(input logic [23:0] p, input logic sof);
      int pos, r, c;
      win_t w;
      pos = sof ? 0 : next_pos;
      img[pos] = p;
      next_pos = (pos + 1) % (W * H);
      r = pos / W;
      c = pos % W;
      if (r >= 2 && c >= 2) begin
         for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
               w[3*i+j] = img[(r-2+i)*W + (c-2+j)];
         exp_q.push_back(w);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) chk_int("unexpected_window", 1, 0);
            else begin
               chk("window", act, exp_q.pop_front());
               windows++;
            end
         end else if (out_valid && !out_ready) begin
            chk_int("in_ready_stall", int'(in_ready), 0);
            if (exp_q.size() != 0) chk("held_window", act, exp_q[0]);
         end
         if (b_out_valid && b_out_ready) begin
            chk("grey_window", b_act, {9{24'h5a5a5a}});
            b_windows++;
         end
      end
   end

   function automatic logic [23:0] pix(input int n);
      return {8'(n), 8'(n + 32), 8'(n + 64)};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      out_ready = (ready_mode == 0) ? 1'b1 :
                  (ready_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b0;
   endtask

   task automatic send(input logic [23:0] p, input logic sof);
      int  tries = 0;
      bit  done = 0;
      in_valid = 1'b1;
      {in_red, in_green, in_blue} = p;
      in_sof = sof;
      while (!done) begin
         @(negedge clk);
         if (in_ready) begin
            model_accept(p, sof);
            done = 1;
         end else if (++tries > 100) begin
            chk_int("send_timeout", tries, 0);
            done = 1;
         end
         tick();
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      ready_mode = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 50) begin
         tick();
         n++;
      end
      tick();
      chk_int("drain_queue_empty", exp_q.size(), 0);
   endtask

   int w0;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; out_ready = 1'b0;
      {in_red, in_green, in_blue} = '0;
      b_in_valid = 1'b0; b_in_sof = 1'b0; b_out_ready = 1'b1;
      #22;
      chk("reset_pixels", act, '0);
      chk_int("reset_out_valid", int'(out_valid), 0);
      chk_int("reset_in_ready", int'(in_ready), 1);
      @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;

      // Basic 4x4 frame
      w0 = windows;
      for (int n = 0; n < 16; n++) send(pix(n), n == 0);
      drain();
      chk_int("basic_count", windows - w0, 4);

      // Backpressure after the first window
      w0 = windows;
      for (int n = 0; n < 11; n++) send(pix(n), n == 0);
      ready_mode = 2; out_ready = 1'b0;
      in_valid = 1'b1; {in_red, in_green, in_blue} = pix(11);
      repeat (5) tick();
      ready_mode = 0; out_ready = 1'b1;
      for (int n = 11; n < 16; n++) send(pix(n), 1'b0);
      drain();
      chk_int("backpressure_count", windows - w0, 4);

      // Resynchronisation at pixel 6
      w0 = windows;
      for (int n = 0; n < 6; n++) send(pix(n), n == 0);
      for (int n = 6; n < 22; n++) send(pix(n), n == 6);
      drain();
      chk_int("resync_count", windows - w0, 4);

      // Reset while a window is pending
      for (int n = 0; n < 11; n++) send(pix(n), n == 0);
      chk_int("pre_reset_valid", int'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      chk_int("async_reset_valid", int'(out_valid), 0);
      chk("async_reset_pixels", act, '0);
      exp_q.delete();
      next_pos = 0;
      @(posedge clk); #1 rst_n = 1'b1;
      w0 = windows;
      for (int n = 0; n < 16; n++) send(pix(n), 1'b0);
      drain();
      chk_int("post_reset_count", windows - w0, 4);

      // Two frames back to back, no second sof
      w0 = windows;
      for (int n = 0; n < 32; n++) send(pix(n), n == 0);
      drain();
      chk_int("frame_wrap_count", windows - w0, 8);

      // Randomised traffic with random backpressure, gaps and resyncs
      ready_mode = 1;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick();
         send(24'($urandom), (i == 0) || ($urandom_range(0, 39) == 0));
      end
      drain();

      // Uniform grey 64x48 frame
      b_in_valid = 1'b1;
      for (int i = 0; i < BW * BH; i++) begin
         b_in_sof = (i == 0);
         @(posedge clk); #1;
      end
      b_in_valid = 1'b0; b_in_sof = 1'b0;
      repeat (4) tick();
      chk_int("grey_count", b_windows, (BW - 2) * (BH - 2));

      chk_int("final_queue_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
